// File: rtl/candy_avb_pio_in_edge_if.sv
// rtl/candy_avb_pio_in_edge_if.sv - Avalon-MM register bus bundle for the input PIO
interface candy_avb_pio_in_edge_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );
endinterface

// File: rtl/candy_avb_pio_in_edge.sv
// rtl/candy_avb_pio_in_edge.sv - input PIO with synchroniser, sticky edge capture and masked irq
module candy_avb_pio_in_edge #(
   parameter int               WIDTH          = 8,
   parameter int               SYNC_STAGES    = 2,
   parameter int               EDGE_TYPE      = 0,
   parameter logic [WIDTH-1:0] IRQ_MASK_RESET = '0
) (
   input  logic                   clk,
   input  logic                   reset,
   candy_avb_pio_in_edge_if.slave avs,
   input  logic [WIDTH-1:0]       in_port,
   output logic                   irq
);

   // Edge detection is only trusted once prev_q holds a genuine post-reset
   // sample; the sync chain itself needs SYNC_STAGES cycles to fill, so the
   // arm point is counted rather than taken after a single cycle.
   localparam logic [2:0] FILL_DONE = 3'(SYNC_STAGES);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync_last;
   logic [WIDTH-1:0] prev_q;
   logic [2:0]       fill_q, fill_d;
   logic             armed_q, armed_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [WIDTH-1:0] cap_q, cap_d;
   logic [WIDTH-1:0] rise, fall, edge_det, clr;
   logic             wr_en;
   logic [31:0]      rdata;
   logic             unused_wdata;

   assign sync_last    = sync_q[SYNC_STAGES-1];
   assign wr_en        = avs.chipselect & ~avs.write_n;
   assign unused_wdata = ^avs.writedata;

   // Synchroniser chain plus a one-cycle-delayed copy of its output
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
         prev_q <= '0;
      end else begin
         sync_q[0] <= in_port;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         prev_q <= sync_last;
      end
   end

   // Priming counter: arm edge detection once both sync_q and prev_q are real samples
   always_comb begin
      fill_d  = (fill_q == FILL_DONE) ? fill_q : fill_q + 3'd1;
      armed_d = armed_q | (fill_q == FILL_DONE);
   end

   // Per-bit edge selection, suppressed until armed
   always_comb begin
      rise     = sync_last & ~prev_q;
      fall     = ~sync_last & prev_q;
      edge_det = '0;
      if (armed_q) begin
         case (EDGE_TYPE)
            0:       edge_det = rise;
            1:       edge_det = fall;
            default: edge_det = rise | fall;
         endcase
      end
   end

   // Register writes: mask load and write-1-to-clear; a new edge beats a clear
   always_comb begin
      mask_d = mask_q;
      clr    = '0;
      if (wr_en) begin
         case (avs.address)
            2'd2:    mask_d = avs.writedata[WIDTH-1:0];
            2'd3:    clr    = avs.writedata[WIDTH-1:0];
            default: ;
         endcase
      end
      cap_d = (cap_q & ~clr) | edge_det;
   end

   // Control/status register state
   always_ff @(posedge clk) begin
      if (reset) begin
         fill_q  <= '0;
         armed_q <= 1'b0;
         mask_q  <= IRQ_MASK_RESET;
         cap_q   <= '0;
      end else begin
         fill_q  <= fill_d;
         armed_q <= armed_d;
         mask_q  <= mask_d;
         cap_q   <= cap_d;
      end
   end

   // Zero-latency read mux, zero-extended above WIDTH
   always_comb begin
      rdata = '0;
      case (avs.address)
         2'd0:    rdata = 32'(sync_last);
         2'd2:    rdata = 32'(mask_q);
         2'd3:    rdata = 32'(cap_q);
         default: rdata = '0;
      endcase
   end

   assign avs.readdata = rdata;
   assign irq          = |(cap_q & mask_q);

endmodule
